enemy_move_ctl: RTL and testbench

ENEMY_MOVE_CTL -- requirements
Module: enemy_move_ctl

---
 rtl/enemy_move_ctl.sv | 152 +++++++++++++++
 tb/tb_enemy_move_ctl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_move_ctl.sv
// Enemy movement controller: tile-aligned random heading choice with wall avoidance,
// single-pixel stepping inside a bounded playfield, and a registered hero-collision flag.
module enemy_move_ctl #(
  parameter int X_INIT   = 64,
  parameter int Y_INIT   = 64,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 992,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 736,
  parameter int HIT_DIST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  rnd,
  input  logic        move_tick,
  input  logic        wall_up,
  input  logic        wall_right,
  input  logic        wall_down,
  input  logic        wall_left,
  input  logic [11:0] hero_x_pos,
  input  logic [11:0] hero_y_pos,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic [1:0]  dir,
  output logic        player_collision
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    CHOOSE = 2'd1,
    STEP   = 2'd2
  } state_t;

  localparam logic signed [13:0] X_MIN_S = 14'(X_MIN);
  localparam logic signed [13:0] X_MAX_S = 14'(X_MAX);
  localparam logic signed [13:0] Y_MIN_S = 14'(Y_MIN);
  localparam logic signed [13:0] Y_MAX_S = 14'(Y_MAX);
  localparam logic [12:0]        HIT_D   = 13'(HIT_DIST);

  state_t      state_reg, state_next;
  logic [11:0] x_reg, x_next;
  logic [11:0] y_reg, y_next;
  logic [1:0]  dir_reg, dir_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [1:0]  cand_reg, cand_next;
  logic        coll_reg, coll_next;

  logic              aligned;
  logic [3:0]        wall_vec;
  logic              cand_blocked;
  logic signed [13:0] nx, ny;
  logic              step_ok;
  logic [11:0]       step_x, step_y;
  logic signed [12:0] dx_s, dy_s;
  logic [12:0]       dx_abs, dy_abs;
  logic              unused_rnd;

  // Only the low two bits of the random word select a heading.
  assign unused_rnd   = ^rnd[5:2];

  assign aligned      = (x_reg[4:0] == 5'd0) && (y_reg[4:0] == 5'd0);
  assign wall_vec     = {wall_left, wall_down, wall_right, wall_up};
  assign cand_blocked = wall_vec[cand_reg];

  // Candidate one-pixel move along the current heading; held if it leaves the field.
  always_comb begin
    nx = $signed({2'b00, x_reg});
    ny = $signed({2'b00, y_reg});
    case (dir_reg)
      2'd0:    ny = ny - 14'sd1;
      2'd1:    nx = nx + 14'sd1;
      2'd2:    ny = ny + 14'sd1;
      default: nx = nx - 14'sd1;
    endcase
  end

  assign step_ok = (nx >= X_MIN_S) && (nx <= X_MAX_S) && (ny >= Y_MIN_S) && (ny <= Y_MAX_S);
  assign step_x  = step_ok ? nx[11:0] : x_reg;
  assign step_y  = step_ok ? ny[11:0] : y_reg;

  assign dx_s      = $signed({1'b0, x_reg}) - $signed({1'b0, hero_x_pos});
  assign dy_s      = $signed({1'b0, y_reg}) - $signed({1'b0, hero_y_pos});
  assign dx_abs    = dx_s[12] ? 13'(-dx_s) : 13'(dx_s);
  assign dy_abs    = dy_s[12] ? 13'(-dy_s) : 13'(dy_s);
  assign coll_next = (dx_abs < HIT_D) && (dy_abs < HIT_D);

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    case (state_reg)
      WAIT: begin
        if (move_tick && !coll_reg) begin
          if (aligned) begin
            state_next = CHOOSE;
            cnt_next   = 2'd0;
            cand_next  = rnd[1:0];
          end else begin
            x_next = step_x;
            y_next = step_y;
          end
        end
      end
      CHOOSE: begin
        if (!cand_blocked) begin
          dir_next   = cand_reg;
          state_next = STEP;
        end else if (cnt_reg == 2'd3) begin
          state_next = WAIT;
        end else begin
          cand_next = cand_reg + 2'd1;
          cnt_next  = cnt_reg + 2'd1;
        end
      end
      STEP: begin
        x_next     = step_x;
        y_next     = step_y;
        state_next = WAIT;
      end
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WAIT;
      x_reg     <= 12'(X_INIT);
      y_reg     <= 12'(Y_INIT);
      dir_reg   <= 2'd0;
      cnt_reg   <= 2'd0;
      cand_reg  <= 2'd0;
      coll_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
      coll_reg  <= coll_next;
    end
  end

  assign x_pos            = x_reg;
  assign y_pos            = y_reg;
  assign dir              = dir_reg;
  assign player_collision = coll_reg;

endmodule

// File: tb/tb_enemy_move_ctl.sv
// Scoreboard bench for enemy_move_ctl: an event-scheduled reference model predicts the
// enemy state after every clock edge; a negedge monitor pops and compares.
module tb_enemy_move_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  rnd = '0;
  logic        move_tick = 1'b0;
  logic        wall_up = 1'b0, wall_right = 1'b0, wall_down = 1'b0, wall_left = 1'b0;
  logic [11:0] hero_x_pos = 12'd1000, hero_y_pos = 12'd1000;
  logic [11:0] x_pos, y_pos;
  logic [1:0]  dir;
  logic        player_collision;

  enemy_move_ctl dut (
    .clk(clk), .rst(rst), .rnd(rnd), .move_tick(move_tick),
    .wall_up(wall_up), .wall_right(wall_right), .wall_down(wall_down), .wall_left(wall_left),
    .hero_x_pos(hero_x_pos), .hero_y_pos(hero_y_pos),
    .x_pos(x_pos), .y_pos(y_pos), .dir(dir), .player_collision(player_collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int d;
    int c;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: positions as plain integers, pending actions scheduled by edge number.
  int m_x, m_y, m_dir, m_coll, m_newdir;
  int e = 0;
  int dir_at, step_at, free_at;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_x = 64; m_y = 64; m_dir = 0; m_coll = 0;
    dir_at = -1; step_at = -1; free_at = -1;
  endtask

  task automatic model_move();
    int nx, ny;
    nx = m_x + ((m_dir == 1) ? 1 : 0) - ((m_dir == 3) ? 1 : 0);
    ny = m_y + ((m_dir == 2) ? 1 : 0) - ((m_dir == 0) ? 1 : 0);
    if (nx >= 0 && nx <= 992 && ny >= 0 && ny <= 736) begin
      m_x = nx;
      m_y = ny;
    end
  endtask

  // Apply one clock of stimulus, predict the post-edge state and hand it to the monitor.
  task automatic cycle(input bit tick, input int r, input bit [3:0] w, input int hx, input int hy);
    int new_coll, n, c;
    exp_t ex;
    move_tick = tick; rnd = 6'(r);
    wall_up = w[0]; wall_right = w[1]; wall_down = w[2]; wall_left = w[3];
    hero_x_pos = 12'(hx); hero_y_pos = 12'(hy);
    e++;
    new_coll = (iabs(m_x - hx) < 16 && iabs(m_y - hy) < 16) ? 1 : 0;
    if (e == dir_at) m_dir = m_newdir;
    if (e == step_at) model_move();
    if (e > free_at && tick && m_coll == 0) begin
      if (m_x % 32 == 0 && m_y % 32 == 0) begin
        c = r % 4;
        n = 0;
        while (n < 4 && w[(c + n) % 4]) n++;
        if (n < 4) begin
          m_newdir = (c + n) % 4;
          dir_at   = e + 1 + n;
          step_at  = e + 2 + n;
          free_at  = e + 2 + n;
        end else begin
          free_at  = e + 4;
        end
      end else begin
        model_move();
      end
    end
    m_coll = new_coll;
    @(posedge clk);
    ex.x = m_x; ex.y = m_y; ex.d = m_dir; ex.c = m_coll;
    sb_q.push_back(ex);
    #1;
  endtask

  // Async reset between edges; outputs must take reset values without waiting for a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check({tag, "_x"}, int'(x_pos), 64);
    check({tag, "_y"}, int'(y_pos), 64);
    check({tag, "_dir"}, int'(dir), 0);
    check({tag, "_coll"}, int'(player_collision), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t ex;
      ex = sb_q.pop_front();
      n_vec++;
      if (int'(x_pos) != ex.x || int'(y_pos) != ex.y || int'(dir) != ex.d ||
          int'(player_collision) != ex.c) begin
        n_err++;
        $display("FAIL state@%0t: got x=%0d y=%0d dir=%0d coll=%0d, expected x=%0d y=%0d dir=%0d coll=%0d",
                 $time, x_pos, y_pos, dir, player_collision, ex.x, ex.y, ex.d, ex.c);
      end
    end
  end

  initial begin
    bit [3:0] w;
    int hx, hy, guard;
    model_reset();
    do_reset("reset_init");

    // Aligned choice: rnd selects right with no walls.
    cycle(1, 6'b000001, 4'b0000, 1000, 1000);
    cycle(0, 0, 4'b0000, 1000, 1000);
    check("aligned_dir_k1", int'(dir), 1);
    cycle(0, 0, 4'b0000, 1000, 1000);
    check("aligned_x_k2", int'(x_pos), 65);
    check("aligned_y_k2", int'(y_pos), 64);

    // Non-aligned stepping on consecutive ticks, running into the next tile boundary.
    for (int i = 0; i < 34; i++) cycle(1, 1, 4'b0000, 1000, 1000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 4'b0000, 1000, 1000);

    // Reset asserted while the controller is in STEP.
    do_reset("reset_init");
    cycle(1, 1, 4'b0000, 1000, 1000);
    cycle(0, 0, 4'b0000, 1000, 1000);
    do_reset("reset_midstep");

    // Blocked search: right and down walled, left found after two rejections.
    cycle(1, 1, 4'b0110, 1000, 1000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 4'b0110, 1000, 1000);
    check("blocked_dir_k3", int'(dir), 3);
    cycle(0, 0, 4'b0110, 1000, 1000);
    check("blocked_x_k4", int'(x_pos), 63);

    // Fully enclosed tile: search gives up, nothing moves.
    do_reset("reset_b");
    cycle(1, 2, 4'b1111, 1000, 1000);
    for (int i = 0; i < 5; i++) cycle(0, 0, 4'b1111, 1000, 1000);
    check("enclosed_x", int'(x_pos), 64);
    check("enclosed_y", int'(y_pos), 64);
    check("enclosed_dir", int'(dir), 0);

    // Collision freezes ticks until the hero leaves.
    cycle(0, 0, 4'b0000, 70, 60);
    check("coll_set", int'(player_collision), 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 4'b0000, 70, 60);
    check("coll_hold_x", int'(x_pos), 64);
    cycle(1, 1, 4'b0000, 100, 64);
    for (int i = 0; i < 6; i++) cycle(1, 1, 4'b0000, 100, 64);

    // Walk left to the field edge, then try to leave it.
    do_reset("reset_c");
    guard = 0;
    while (m_x != 0 && guard < 400) begin
      cycle(1, 3, 4'b0000, 1000, 1000);
      guard++;
    end
    check("walk_guard", (guard < 400) ? 1 : 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 4'b0000, 1000, 1000);
    cycle(1, 3, 4'b0000, 1000, 1000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 4'b0000, 1000, 1000);
    check("edge_x", int'(x_pos), 0);
    check("edge_dir", int'(dir), 3);

    // Random traffic, walls only changing while the controller is idle.
    do_reset("reset_d");
    w = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if (e + 1 > free_at) w = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        hx = m_x + int'($urandom_range(0, 40)) - 20;
        hy = m_y + int'($urandom_range(0, 40)) - 20;
        if (hx < 0) hx = 0;
        if (hy < 0) hy = 0;
      end else begin
        hx = int'($urandom_range(0, 4095));
        hy = int'($urandom_range(0, 4095));
      end
      cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)), w, hx, hy);
    end
    cycle(0, 0, 4'b0000, 1000, 1000);
    @(negedge clk);
    #1;
    check("queue_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
